// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, forward S-box and GF(2^8) arithmetic.
package aes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KSEL,
      ARK,
      RND,
      DONE
   } state_t;

   localparam int NR = 10;

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// Request/response bundle between the AES cipher core and its host / key-expansion stage.
interface aes_cipher_core_if;

   logic         start;
   logic [127:0] din;
   logic [127:0] rk;
   logic         key_sel;
   logic         busy;
   logic         done;
   logic [127:0] dout;

   modport master (
      output start, din, rk,
      input  key_sel, busy, done, dout
   );

   modport slave (
      input  start, din, rk,
      output key_sel, busy, done, dout
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; build option AES_CIPHER_SBOX_ROM_EN selects the table
// implementation, otherwise the S-box is computed as GF(2^8) inverse plus affine transform.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

`ifdef AES_CIPHER_SBOX_ROM_EN

   assign y = SBOX[a];

`else

   // a^254 is the multiplicative inverse for a != 0 and yields 0 for a == 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] v);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = v;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] inv;

   assign inv = gf_inv(a);
   assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

`endif

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys supplied by an
// external key-expansion stage steered through key_sel.
module aes_cipher_core #(
   parameter int NR = aes_pkg::NR
) (
   input logic              CLK,
   input logic              RST,
   aes_cipher_core_if.slave bus
);

   import aes_pkg::*;

   localparam logic [3:0] LAST = 4'(NR);

   state_t       state, state_nxt;
   logic [3:0]   cnt, cnt_nxt;
   logic [127:0] blk, blk_nxt;
   logic [127:0] dout_r, dout_nxt;

   logic [7:0]   sb [16];
   logic [127:0] sr_blk;
   logic [127:0] mc_blk;

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = col;
      return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
              xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
   endfunction

   // Byte k of the block is s[k%4, k/4]; it lives in bits [127-8k -: 8].
   for (genvar k = 0; k < 16; k++) begin : g_sbox
      aes_sbox u_sbox (
         .a (blk[127-8*k -: 8]),
         .y (sb[k])
      );
   end

   always_comb begin
      sr_blk = '0;
      mc_blk = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_blk[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc_blk[127-32*c -: 32] = mix_column(sr_blk[127-32*c -: 32]);
      end
   end

   // NOTE: every next-state variable is given a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      blk_nxt   = blk;
      dout_nxt  = dout_r;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               blk_nxt   = bus.din;
               state_nxt = KSEL;
            end
         end
         KSEL: state_nxt = ARK;
         ARK: begin
            blk_nxt   = blk ^ bus.rk;
            cnt_nxt   = 4'd1;
            state_nxt = RND;
         end
         RND: begin
            cnt_nxt = cnt + 4'd1;
            if (cnt == LAST) begin
               blk_nxt   = sr_blk ^ bus.rk;
               dout_nxt  = sr_blk ^ bus.rk;
               state_nxt = DONE;
            end else begin
               blk_nxt = mc_blk ^ bus.rk;
            end
         end
         DONE: begin
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         blk    <= '0;
         dout_r <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         blk    <= blk_nxt;
         dout_r <= dout_nxt;
      end
   end

   assign bus.key_sel = (state == KSEL);
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.dout    = dout_r;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: FIPS-197 vectors, randomized blocks against a
// behavioural AES model, handshake corner cases and mid-operation reset.
module tb_aes_cipher_core;

   typedef logic [0:10][127:0] sched_t;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic   CLK = 1'b0;
   logic   RST = 1'b1;
   int     vectors = 0;
   int     miscompares = 0;
   logic [7:0] sbox_m [256];
   sched_t sched = '0;
   int     kidx = 0;

   aes_cipher_core_if bus ();

   aes_cipher_core #(.NR(10)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Key-expansion stage model: reload on key_sel, otherwise step one round key per clock.
   always @(posedge CLK) begin
      if (bus.key_sel) kidx <= 0;
      else if (kidx < 10) kidx <= kidx + 1;
   end
   assign bus.rk = sched[kidx];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: brute-force inverse, then bitwise affine map.
   function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] cst;
      inv = 8'h00;
      cst = 8'h63;
      for (int y = 1; y < 256; y++) begin
         if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      end
      return s;
   endfunction

   function automatic sched_t key_sched(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      sched_t      ks;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t[31:24] = t[31:24] ^ rcon;
            rcon = m_mul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return ks;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      sched_t      ks;
      logic [7:0]  s [4][4];
      logic [7:0]  t [4][4];
      logic [127:0] ct;
      logic [127:0] rkv;
      ks  = key_sched(key);
      rkv = ks[0];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(r+4*c) -: 8] ^ rkv[127-8*(r+4*c) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         rkv = ks[rnd];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_m[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               if (rnd == 10) s[r][c] = t[r][c];
               else s[r][c] = m_mul(8'h02, t[r][c]) ^ m_mul(8'h03, t[(r+1)%4][c])
                              ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               s[r][c] = s[r][c] ^ rkv[127-8*(r+4*c) -: 8];
            end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            ct[127-8*(r+4*c) -: 8] = s[r][c];
      return ct;
   endfunction

   // One encryption; with disturb set, din is scrambled after acceptance and start pulses in cycle 5.
   task automatic encrypt(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                          input string tag, input bit disturb);
      int n;
      sched     = key_sched(key);
      bus.din   = pt;
      bus.start = 1'b1;
      tick();
      n = 1;
      bus.start = 1'b0;
      check({tag, " key_sel"}, 128'(bus.key_sel), 128'd1);
      check({tag, " busy"}, 128'(bus.busy), 128'd1);
      while (!bus.done && n < 20) begin
         if (disturb) begin
            bus.din   = rand128();
            bus.start = (n == 5);
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 128'(n), 128'd13);
      check({tag, " dout"}, bus.dout, exp);
      tick();
      check({tag, " done width"}, 128'(bus.done), 128'd0);
      check({tag, " idle"}, 128'(bus.busy), 128'd0);
      check({tag, " hold"}, bus.dout, exp);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (bus.busy && n < 30) begin
         tick();
         n++;
      end
      check("drain busy", 128'(bus.busy), 128'd0);
   endtask

   initial begin
      int pulses;
      int p0;
      int p1;
      for (int x = 0; x < 256; x++) sbox_m[x] = m_sbox_calc(8'(x));

      // Reset with start high: reset wins.
      bus.start = 1'b1;
      bus.din   = rand128();
      RST = 1'b1;
      tick();
      tick();
      check("rst busy", 128'(bus.busy), 128'd0);
      check("rst done", 128'(bus.done), 128'd0);
      check("rst key_sel", 128'(bus.key_sel), 128'd0);
      check("rst dout", bus.dout, 128'd0);
      bus.start = 1'b0;
      RST = 1'b0;
      tick();
      check("post-rst idle", 128'(bus.busy), 128'd0);

      encrypt(PT_B, KEY_B, CT_B, "appB", 1'b0);
      encrypt(PT_C, KEY_C, CT_C, "appC1", 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [127:0] k;
         logic [127:0] p;
         logic [127:0] e;
         k = rand128();
         p = rand128();
         e = aes_ref(p, k);
         encrypt(p, k, e, $sformatf("rand%0d", i), 1'b0);
         repeat ($urandom_range(0, 3)) begin
            tick();
            check("gap hold", bus.dout, e);
         end
      end

      // start held high for 30 cycles
      sched     = key_sched(KEY_B);
      bus.din   = PT_B;
      bus.start = 1'b1;
      pulses = 0;
      p0 = 0;
      p1 = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (bus.done) begin
            if (pulses == 0) p0 = i;
            else p1 = i;
            check("hold-start dout", bus.dout, CT_B);
            pulses++;
         end
      end
      bus.start = 1'b0;
      check("hold-start pulses", 128'(pulses), 128'd2);
      check("hold-start first", 128'(p0), 128'd13);
      check("hold-start spacing", 128'(p1 - p0), 128'd14);
      drain();

      encrypt(PT_C, KEY_C, CT_C, "disturb", 1'b1);
      tick();
      check("disturb no queue", 128'(bus.busy), 128'd0);

      // Reset in cycle 7 of an operation.
      sched     = key_sched(KEY_C);
      bus.din   = PT_C;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (6) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort busy", 128'(bus.busy), 128'd0);
      check("abort dout", bus.dout, 128'd0);
      check("abort done", 128'(bus.done), 128'd0);
      pulses = 0;
      repeat (20) begin
         tick();
         if (bus.done) pulses++;
      end
      check("abort no done", 128'(pulses), 128'd0);
      encrypt(PT_B, KEY_B, CT_B, "after abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/aes_cipher_core.md
AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

Interface
REQ-001 SHALL have parameter: NR, 10, number of cipher rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updated on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request to encrypt din; sampled only in IDLE.
REQ-005 SHALL have port: din  input  128  plaintext block; din[127:120] is state byte s[0,0], column-major order.
REQ-006 SHALL have port: rk  input  128  current round key {w0,w1,w2,w3} from the key-expansion stage.
REQ-007 SHALL have port: key_sel  output  1  drives key-expansion sel; high reloads the cipher key, low advances one round key per clock.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when dout becomes valid.
REQ-010 SHALL have port: dout  output  128  ciphertext, same byte order as din.

Function
REQ-011 SHALL implement FSM states IDLE, KSEL, ARK, RND, DONE.
REQ-012 IDLE: start=1 SHALL latch din into the state register and go to KSEL; start=0 SHALL stay in IDLE.
REQ-013 KSEL: key_sel SHALL be 1 (decoded from state, not registered separately); next state is ARK. key_sel SHALL be 0 in all other states.
REQ-014 ARK: the state register SHALL be set to state XOR rk, i.e. XOR with round key 0; the round counter SHALL be set to 1; next state is RND.
REQ-015 RND: the state register SHALL be set to AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk) when the counter is 1..9, and to AddRoundKey(ShiftRows(SubBytes(state)), rk) when the counter is 10.
REQ-016 RND: the counter SHALL increment each cycle; at counter 10 the next state is DONE.
REQ-017 DONE: done SHALL be 1 and dout SHALL equal the state register; next state is IDLE.
REQ-018 With start sampled high in cycle 0, done SHALL be high in cycle 13 (1 KSEL + 1 ARK + 10 RND + 1 DONE cycle).
REQ-019 dout SHALL hold the last ciphertext until the next start is accepted.
REQ-020 start SHALL be ignored while busy=1; no queuing.
REQ-021 din SHALL be sampled only on the accepting edge; later changes to din SHALL have no effect.
REQ-022 The next start SHALL be accepted no earlier than the cycle after DONE (minimum 14-cycle issue interval).
REQ-023 MixColumns SHALL use GF(2^8) multiplication with reduction polynomial 0x11B; xtime(a) = (a<<1) XOR (0x1B if a[7]).

Reset
REQ-024 RST=1 at a rising edge SHALL force state IDLE, counter 0, state register 0, key_sel 0, busy 0, done 0, dout 0.
REQ-025 RST SHALL take priority over start.
REQ-026 RST asserted mid-operation SHALL abort the operation without producing a done pulse.

Configuration
REQ-027 With macro AES_CIPHER_SBOX_ROM_EN defined, SubBytes SHALL use a 256-entry constant S-box table.
REQ-028 Without AES_CIPHER_SBOX_ROM_EN, SubBytes SHALL compute the GF(2^8) multiplicative inverse (0 maps to 0) followed by the FIPS-197 affine transform with constant 0x63.
REQ-029 Both builds SHALL be cycle- and bit-identical.

Structure
REQ-030 Package aes_pkg SHALL hold: FSM state enum; NR; the 256-byte S-box constant; the xtime and GF-multiply functions.
REQ-031 SHALL instantiate 16 copies of sub-module aes_sbox (8-bit in, 8-bit out, combinational) containing the macro-selected implementation; all other round logic SHALL be inline.

Verification
REQ-032 Directed test: FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, din 3243f6a8885a308d313198a2e0370734 -> dout 3925841d02dc09fbdc118597196a0b32 with done high in cycle 13.
REQ-033 Directed test: FIPS-197 App. C.1, key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff -> dout 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Directed test: start held high for 30 cycles -> exactly two done pulses, 14 cycles apart, both with correct ciphertext.
REQ-035 Directed test: start pulsed in cycle 5 of an operation -> ignored; din changed after acceptance -> dout unchanged.
REQ-036 Directed test: RST asserted in cycle 7 of an operation -> next cycle busy=0, dout=0, no done pulse; a fresh start then gives the App. B result.
REQ-037 Directed test: run the App. B and App. C.1 tests with and without AES_CIPHER_SBOX_ROM_EN -> identical waveforms.
